// File: rtl/enc_pkg.sv
// Shared types and helpers for the one-hot encoder pipeline.
//   N         : number of one-hot input lines
//   W         : width of the encoded index
//   enc_res_t : one encoded result {code, zero, multi}
//   enc_f     : combinational priority encode of a one-hot vector
package enc_pkg;

    localparam int N = 4;
    localparam int W = $clog2(N);

    typedef struct packed {
        logic [W-1:0] code;
        logic         zero;
        logic         multi;
    } enc_res_t;

    // Entry count of the two-deep output buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    // Highest set bit wins; an all-zero vector encodes to 0 with zero set.
    function automatic enc_res_t enc_f(input logic [N-1:0] vec);
        enc_res_t    res;
        int unsigned ones;
        res  = '0;
        ones = 0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                res.code = W'(i);
                ones     = ones + 1;
            end
        end
        res.zero  = (vec == '0);
        res.multi = (ones > 1);
        return res;
    endfunction

endpackage

// File: rtl/enc_skid_buf.sv
// Two-entry FIFO buffer for encoded results with valid/ready on both sides.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : upstream handshake, in_data captured on accept
//   out_valid / out_ready: downstream handshake, out_data is the head entry
//   accept               : pulses when an input is taken (drives statistics)
// in_ready depends only on the registered state, so there is no
// combinational path from out_ready back to in_ready.
module enc_skid_buf
    import enc_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  enc_res_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output enc_res_t out_data,
    output logic     accept
);

    buf_state_t state_reg;
    buf_state_t state_next;
    enc_res_t   head_reg;
    enc_res_t   tail_reg;
    logic       pop;
    logic       load_head;
    logic       load_tail;
    logic       shift_tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_tail = 1'b0;
        in_ready   = (state_reg != ST_FULL);
        out_valid  = (state_reg != ST_EMPTY);
        accept     = in_valid & in_ready;
        pop        = out_valid & out_ready;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_ONE;
                    load_head  = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !pop) begin
                    state_next = ST_FULL;
                    load_tail  = 1'b1;
                end else if (pop && !accept) begin
                    state_next = ST_EMPTY;
                end else if (accept && pop) begin
                    // Head leaves and the new entry takes its place.
                    load_head  = 1'b1;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_next = ST_ONE;
                    shift_tail = 1'b1;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (load_head) begin
                head_reg <= in_data;
            end else if (shift_tail) begin
                head_reg <= tail_reg;
            end
            if (load_tail) begin
                tail_reg <= in_data;
            end
        end
    end

    assign out_data = head_reg;

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Registered 4-to-2 priority encoder with valid/ready handshakes, a two-entry
// output buffer and saturating statistics counters.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_vec = {y3,y2,y1,y0}
//   out_valid/out_ready  : output handshake
//   out_code             : highest set index, {a,b}
//   out_zero, out_multi  : source vector was zero-hot / multi-hot
//   tot_cnt, err_cnt     : accepted vectors / accepted vectors flagged bad
module onehot_encoder_pipe
    import enc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_code,
    output logic             out_zero,
    output logic             out_multi,
    output logic [CNT_W-1:0] tot_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    enc_res_t in_res;
    enc_res_t out_res;
    logic     accept;
    logic [1:0] cnt_inc;

    assign in_res = enc_f(in_vec);

    enc_skid_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_res),
        .accept    (accept)
    );

    assign out_code  = out_res.code;
    assign out_zero  = out_res.zero;
    assign out_multi = out_res.multi;

    // Index 0 counts every accept, index 1 only flagged ones.
    assign cnt_inc[0] = accept;
    assign cnt_inc[1] = accept & (in_res.zero | in_res.multi);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign tot_cnt = g_cnt[0].cnt_reg;
    assign err_cnt = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Testbench for onehot_encoder_pipe: directed steps plus random traffic,
// checked against a queue-based reference model.
module tb_onehot_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_zero;
    logic       out_multi;
    logic [7:0] tot_cnt;
    logic [7:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    onehot_encoder_pipe #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_zero  (out_zero),
        .out_multi (out_multi),
        .tot_cnt   (tot_cnt),
        .err_cnt   (err_cnt)
    );

    // Reference model: a FIFO of raw vectors holding at most two entries.
    logic [3:0] q[$];
    int         m_tot;
    int         m_err;
    bit         m_acc;
    bit         m_pop;

    function automatic int ref_code(input logic [3:0] v);
        if (v == 4'd0) return 0;
        return $clog2(int'(v) + 1) - 1;
    endfunction

    function automatic bit ref_bad(input logic [3:0] v);
        return (v == 4'd0) || ($countones(v) > 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_tot = 0;
            m_err = 0;
        end else begin
            m_acc = in_valid && (q.size() < 2);
            m_pop = out_ready && (q.size() > 0);
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                q.push_back(in_vec);
                if (m_tot < 255) m_tot = m_tot + 1;
                if (ref_bad(in_vec) && m_err < 255) m_err = m_err + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_code", 32'(out_code), 32'(ref_code(q[0])));
            chk("out_zero", 32'(out_zero), 32'(q[0] == 4'd0));
            chk("out_multi", 32'(out_multi), 32'($countones(q[0]) > 1));
        end
        chk("tot_cnt", 32'(tot_cnt), 32'(m_tot));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 4'bxxxx;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_code", 32'(out_code), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        chk("rst_multi", 32'(out_multi), 32'd0);
        chk("rst_tot", 32'(tot_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);

        // Walking one, back-to-back
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_vec   = 4'b0001 << i;
            step();
            chk("walk_code", 32'(out_code), 32'(i));
            chk("walk_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        in_vec   = 4'bxxxx;
        step();
        chk("walk_tot", 32'(tot_cnt), 32'd4);

        // Zero-hot and multi-hot
        in_valid = 1'b1; in_vec = 4'b0000;
        step();
        chk("zero_flag", 32'(out_zero), 32'd1);
        chk("zero_err", 32'(err_cnt), 32'd1);
        in_vec = 4'b1010;
        step();
        chk("multi_code", 32'(out_code), 32'd3);
        chk("multi_flag", 32'(out_multi), 32'd1);
        chk("multi_err", 32'(err_cnt), 32'd2);
        in_valid = 1'b0;
        step();

        // Backpressure: fill, hold a third, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_vec = 4'b0001;
        step();
        in_vec = 4'b0100;
        step();
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        in_vec = 4'b1000;
        repeat (3) step();
        chk("bp_head0", 32'(out_code), 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_head1", 32'(out_code), 32'd2);
        step();
        chk("bp_head2", 32'(out_code), 32'd3);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Steady state ONE with both sides active
        out_ready = 1'b0;
        in_valid = 1'b1; in_vec = 4'b0010;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_vec = 4'($urandom_range(0, 15));
            step();
            chk("one_state", 32'({out_valid, in_ready}), 32'd3);
        end
        in_valid = 1'b0;
        step();

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_vec    = 4'($urandom_range(0, 15));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Saturation
        in_valid = 1'b1; in_vec = 4'b1100;
        repeat (300) step();
        in_valid = 1'b0;
        step();
        chk("sat_tot", 32'(tot_cnt), 32'd255);
        chk("sat_err", 32'(err_cnt), 32'd255);

        // Reset with two entries buffered
        out_ready = 1'b0;
        in_valid = 1'b1; in_vec = 4'b0001;
        step();
        in_vec = 4'b0100;
        step();
        in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_tot", 32'(tot_cnt), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_empty", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_vec = 4'b0010;
        step();
        chk("post_rst_code", 32'(out_code), 32'd1);
        chk("post_rst_tot", 32'(tot_cnt), 32'd1);
        in_valid = 1'b0;
        step();

        // Loop-back from a 2x4 decoder
        for (int ab = 0; ab < 4; ab++) begin
            logic [1:0] abv;
            abv = 2'(ab);
            in_valid = 1'b1;
            in_vec   = {abv == 2'd3, abv == 2'd2, abv == 2'd1, abv == 2'd0};
            step();
            chk("loopback", 32'(out_code), 32'(ab));
        end
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
